// File: rtl/rtc_timekeeper.sv
// Time-of-day counter: divides clk down to a 1 Hz tick and keeps hh:mm:ss with
// run/hold, increment buttons, validated load, 12/24 h display and a sticky alarm.
`timescale 1ns/1ps

module rtc_timekeeper #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int PRESCALE_W    = $clog2(TICKS_PER_SEC)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       mode_12h,
    input  logic       inc_min,
    input  logic       inc_hr,
    input  logic       load_valid,
    input  logic [4:0] load_hr,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       pm,
    output logic       tick_1hz,
    output logic       load_err,
    output logic       alarm_irq
);

    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

    logic [PRESCALE_W-1:0] presc_q, presc_n;
    logic [5:0]            sec_q, sec_c, sec_n;
    logic [5:0]            min_q, min_c, min_n;
    logic [4:0]            hr_q, hr_c, hr_n;
    logic                  inc_min_q, inc_hr_q;
    logic                  tick_q, load_err_q, alarm_irq_q;

    logic                  tick, load_ok, min_fire, hr_fire;
    logic                  time_upd, alarm_hit, irq_n;

    always_comb begin
        load_ok  = load_valid && (load_hr <= 5'd23) && (load_min <= 6'd59)
                   && (load_sec <= 6'd59);
        tick     = run_en && (presc_q == PRESC_LAST);
        min_fire = inc_min && !inc_min_q;
        hr_fire  = inc_hr && !inc_hr_q;
    end

    // An accepted load restarts the second so the new time is held a full second.
    always_comb begin
        presc_n = presc_q + 1'b1;
        if (!run_en || load_ok || tick) begin
            presc_n = '0;
        end
    end

    always_comb begin
        sec_c = sec_q;
        min_c = min_q;
        hr_c  = hr_q;
        if (tick) begin
            if (sec_q == 6'd59) begin
                sec_c = 6'd0;
                if (min_q == 6'd59) begin
                    min_c = 6'd0;
                    hr_c  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                end else begin
                    min_c = min_q + 6'd1;
                end
            end else begin
                sec_c = sec_q + 6'd1;
            end
        end
    end

    // Buttons act on the already-carried time and never ripple into the next field.
    always_comb begin
        sec_n = sec_c;
        min_n = min_c;
        hr_n  = hr_c;
        if (load_ok) begin
            sec_n = load_sec;
            min_n = load_min;
            hr_n  = load_hr;
        end else begin
            if (min_fire) begin
                min_n = (min_c == 6'd59) ? 6'd0 : min_c + 6'd1;
            end
            if (hr_fire) begin
                hr_n = (hr_c == 5'd23) ? 5'd0 : hr_c + 5'd1;
            end
        end
    end

    // Match only when the time is written this edge; set beats clear.
    always_comb begin
        time_upd  = load_ok || tick || min_fire || hr_fire;
        alarm_hit = alarm_arm && time_upd && (hr_n == alarm_hr)
                    && (min_n == alarm_min) && (sec_n == 6'd0);
        irq_n     = alarm_irq_q;
        if (alarm_hit) begin
            irq_n = 1'b1;
        end else if (alarm_ack || !alarm_arm) begin
            irq_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
            inc_min_q   <= 1'b0;
            inc_hr_q    <= 1'b0;
            tick_q      <= 1'b0;
            load_err_q  <= 1'b0;
            alarm_irq_q <= 1'b0;
        end else begin
            presc_q     <= presc_n;
            sec_q       <= sec_n;
            min_q       <= min_n;
            hr_q        <= hr_n;
            inc_min_q   <= inc_min;
            inc_hr_q    <= inc_hr;
            tick_q      <= tick && !load_ok;
            load_err_q  <= load_valid && !load_ok;
            alarm_irq_q <= irq_n;
        end
    end

    // Display mapping is purely combinational so mode changes show immediately.
    always_comb begin
        hr = hr_q;
        if (mode_12h) begin
            if (hr_q == 5'd0) begin
                hr = 5'd12;
            end else if (hr_q > 5'd12) begin
                hr = hr_q - 5'd12;
            end
        end
    end

    assign pm        = (hr_q >= 5'd12);
    assign sec       = sec_q;
    assign min       = min_q;
    assign tick_1hz  = tick_q;
    assign load_err  = load_err_q;
    assign alarm_irq = alarm_irq_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: directed scenarios plus random stimulus against a
// seconds-of-day reference model checked every cycle.
`timescale 1ns/1ps

module tb_rtc_timekeeper;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_en = 1'b1, mode_12h = 1'b0, inc_min = 1'b0, inc_hr = 1'b0;
    logic       load_valid = 1'b0;
    logic [4:0] load_hr = '0, alarm_hr = '0;
    logic [5:0] load_min = '0, load_sec = '0, alarm_min = '0;
    logic       alarm_arm = 1'b0, alarm_ack = 1'b0;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic       pm, tick_1hz, load_err, alarm_irq;

    int         n_checks = 0;
    int         n_errs = 0;
    bit         chk_on = 1'b0;
    logic [16:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    rtc_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .mode_12h(mode_12h),
        .inc_min(inc_min), .inc_hr(inc_hr), .load_valid(load_valid),
        .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_arm(alarm_arm),
        .alarm_ack(alarm_ack), .sec(sec), .min(min), .hr(hr), .pm(pm),
        .tick_1hz(tick_1hz), .load_err(load_err), .alarm_irq(alarm_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        int t;     // seconds since midnight
        int cnt;   // cycles into the current second
        bit mq;
        bit hq;
        bit irq;
        bit tick;
        bit err;
    } model_t;

    model_t md = '0;

    function automatic model_t model_step(model_t s, bit run, bit im, bit ih, bit lv,
                                          int lh, int lm, int ls, int ah, int am,
                                          bit arm, bit ack);
        model_t n = s;
        bit ld_ok = lv && lh <= 23 && lm <= 59 && ls <= 59;
        bit tk    = run && (s.cnt == TPS - 1);
        bit fm    = im && !s.mq;
        bit fh    = ih && !s.hq;
        bit upd   = 1'b0;
        int h, m, sc;
        n.tick = 1'b0;
        if (ld_ok) begin
            n.t = lh * 3600 + lm * 60 + ls;
            n.cnt = 0;
            upd = 1'b1;
        end else begin
            n.cnt = (run && !tk) ? s.cnt + 1 : 0;
            if (tk) begin
                n.t = (s.t + 1) % 86400;
                n.tick = 1'b1;
                upd = 1'b1;
            end
            h = n.t / 3600; m = (n.t / 60) % 60; sc = n.t % 60;
            if (fm) begin m = (m + 1) % 60; upd = 1'b1; end
            if (fh) begin h = (h + 1) % 24; upd = 1'b1; end
            n.t = h * 3600 + m * 60 + sc;
        end
        n.err = lv && !ld_ok;
        n.mq  = im;
        n.hq  = ih;
        if (arm && upd && n.t == ah * 3600 + am * 60) n.irq = 1'b1;
        else if (ack || !arm) n.irq = 1'b0;
        return n;
    endfunction

    function automatic int disp_hr(int h, bit m12);
        if (!m12) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) md <= '0;
        else md <= model_step(md, run_en, inc_min, inc_hr, load_valid, int'(load_hr),
                              int'(load_min), int'(load_sec), int'(alarm_hr),
                              int'(alarm_min), alarm_arm, alarm_ack);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("m_sec", 32'(sec), md.t % 60);
            check("m_min", 32'(min), (md.t / 60) % 60);
            check("m_hr", 32'(hr), disp_hr(md.t / 3600, mode_12h));
            check("m_pm", 32'(pm), (md.t / 3600) >= 12);
            check("m_tick", 32'(tick_1hz), md.tick);
            check("m_err", 32'(load_err), md.err);
            check("m_irq", 32'(alarm_irq), md.irq);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load_valid = 1'b1;
        load_hr = 5'(h); load_min = 6'(m); load_sec = 6'(s);
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            cyc();
            cycles++;
        end while (!tick_1hz && cycles < 4 * TPS);
    endtask

    // ---------------- scoreboard ----------------
    task automatic sb_push(input int h, input int m, input int s);
        exp_q.push_back({5'(h), 6'(m), 6'(s)});
    endtask

    task automatic sb_check(input string tag);
        logic [16:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {15'd0, hr, min, sec}, {15'd0, e});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int c;
        int bad;
        #1 rst = 1'b0;
        #1;
        check("rst_sec", 32'(sec), 0);
        check("rst_min", 32'(min), 0);
        check("rst_hr24", 32'(hr), 0);
        check("rst_pm", 32'(pm), 0);
        check("rst_tick", 32'(tick_1hz), 0);
        check("rst_err", 32'(load_err), 0);
        check("rst_irq", 32'(alarm_irq), 0);
        mode_12h = 1'b1;
        #1 check("rst_hr12", 32'(hr), 12);
        mode_12h = 1'b0;
        chk_on = 1'b1;
        cyc(2);
        rst = 1'b1;

        // tick cadence from reset
        wait_tick(c);
        check("tick1_gap", c, TPS);
        check("tick1_sec", 32'(sec), 1);
        repeat (2) begin
            wait_tick(c);
            check("tick_gap", c, TPS);
        end
        check("tick3_sec", 32'(sec), 3);

        // midnight wrap and 12 h mapping
        do_load(23, 59, 59);
        wait_tick(c);
        check("wrap_gap", c, TPS);
        sb_push(0, 0, 0);
        sb_check("wrap_time");
        check("wrap_pm", 32'(pm), 0);
        check("wrap_tick", 32'(tick_1hz), 1);
        mode_12h = 1'b1;
        do_load(12, 0, 0);
        check("noon_hr", 32'(hr), 12);
        check("noon_pm", 32'(pm), 1);
        do_load(0, 34, 10);
        check("midn_hr", 32'(hr), 12);
        check("midn_pm", 32'(pm), 0);
        mode_12h = 1'b0;

        // rejected loads
        run_en = 1'b0;
        do_load(10, 20, 30);
        load_valid = 1'b1; load_hr = 5'd24; load_min = 6'd5; load_sec = 6'd5;
        cyc();
        load_valid = 1'b0;
        check("rej_hr_err", 32'(load_err), 1);
        sb_push(10, 20, 30);
        sb_check("rej_hr_time");
        cyc();
        check("rej_err_pulse", 32'(load_err), 0);
        load_valid = 1'b1; load_hr = 5'd3; load_min = 6'd60; load_sec = 6'd5;
        cyc();
        load_valid = 1'b0;
        check("rej_min_err", 32'(load_err), 1);
        sb_push(10, 20, 30);
        sb_check("rej_min_time");

        // increment buttons while holding
        do_load(22, 59, 30);
        inc_min = 1'b1; cyc(); inc_min = 1'b0; cyc();
        inc_min = 1'b1; cyc(10); inc_min = 1'b0; cyc();
        inc_hr = 1'b1; cyc(); inc_hr = 1'b0; cyc();
        sb_push(23, 1, 30);
        sb_check("inc_time");
        check("inc_notick", 32'(tick_1hz), 0);

        // alarm
        alarm_hr = 5'd7; alarm_min = 6'd0; alarm_arm = 1'b1; run_en = 1'b1;
        do_load(6, 59, 59);
        check("alm_pre", 32'(alarm_irq), 0);
        wait_tick(c);
        check("alm_gap", c, TPS);
        sb_push(7, 0, 0);
        sb_check("alm_time");
        check("alm_set", 32'(alarm_irq), 1);
        alarm_ack = 1'b1; cyc(); alarm_ack = 1'b0;
        check("alm_ack", 32'(alarm_irq), 0);
        alarm_ack = 1'b1;
        do_load(7, 0, 0);
        alarm_ack = 1'b0;
        check("alm_setwins", 32'(alarm_irq), 1);
        cyc();
        check("alm_sticky", 32'(alarm_irq), 1);
        alarm_arm = 1'b0; cyc();
        check("alm_disarm", 32'(alarm_irq), 0);

        // asynchronous reset between edges
        run_en = 1'b0;
        do_load(5, 17, 42);
        cyc(2);
        rst = 1'b0;
        #1;
        check("arst_sec", 32'(sec), 0);
        check("arst_min", 32'(min), 0);
        check("arst_hr", 32'(hr), 0);
        check("arst_pm", 32'(pm), 0);
        mode_12h = 1'b1;
        #1 check("arst_hr12", 32'(hr), 12);
        mode_12h = 1'b0;
        cyc(2);
        rst = 1'b1; run_en = 1'b1;
        wait_tick(c);
        check("arst_gap", c, TPS);
        check("arst_sec1", 32'(sec), 1);

        // random phase
        alarm_arm = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            run_en    = ($urandom_range(0, 9) != 0);
            inc_min   = ($urandom_range(0, 7) == 0);
            inc_hr    = ($urandom_range(0, 15) == 0);
            alarm_ack = ($urandom_range(0, 9) == 0);
            alarm_arm = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 31) == 0) mode_12h = ~mode_12h;
            if ($urandom_range(0, 63) == 0) begin
                alarm_hr  = 5'($urandom_range(0, 23));
                alarm_min = 6'($urandom_range(0, 59));
            end
            load_valid = 1'b0;
            c = $urandom_range(0, 39);
            if (c == 0) begin
                load_valid = 1'b1;
                load_hr  = 5'($urandom_range(0, 23));
                load_min = 6'($urandom_range(0, 59));
                load_sec = 6'($urandom_range(0, 59));
            end else if (c == 1) begin
                load_valid = 1'b1;
                load_hr  = alarm_hr;
                load_min = (alarm_min == 6'd0) ? 6'd59 : alarm_min - 6'd1;
                load_sec = 6'($urandom_range(55, 59));
                if (alarm_min == 6'd0) load_hr = (alarm_hr == 5'd0) ? 5'd23 : alarm_hr - 5'd1;
            end else if (c == 2) begin
                run_en = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
                load_valid = 1'b1;
                load_hr  = 5'($urandom_range(0, 23));
                load_min = 6'($urandom_range(0, 59));
                load_sec = 6'($urandom_range(0, 59));
                bad = $urandom_range(0, 2);
                if (bad == 0) load_hr = 5'($urandom_range(24, 31));
                else if (bad == 1) load_min = 6'($urandom_range(60, 63));
                else load_sec = 6'($urandom_range(60, 63));
            end
            cyc();
        end
        load_valid = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
        cyc(2);
        chk_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
